// File: rtl/addr_match_seq.sv
// Breakpoint/event sequencer behind an address comparator chain: qualifies
// active-low equal samples on bus strobes, counts passes and raises a held trigger.
module addr_match_seq #(
  parameter int CWIDTH = 8
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_eq_,
  input  logic              i_stb,
  input  logic              i_ld,
  input  logic [CWIDTH-1:0] i_cnt_in,
  input  logic              i_arm,
  input  logic              i_disarm,
  input  logic              i_ack,
  output logic              o_trig,
  output logic              o_armed,
  output logic [CWIDTH-1:0] o_cnt,
  output logic [CWIDTH-1:0] o_hits,
  output logic              o_ovr
);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_ARMED = 2'd1,
    S_FIRE  = 2'd2
  } state_t;

  state_t              r_state;
  logic                r_trig;
  logic                r_armed;
  logic [CWIDTH-1:0]   r_cnt;
  logic [CWIDTH-1:0]   r_pre;
  logic [CWIDTH-1:0]   r_hits;
  logic                r_ovr;

  state_t              w_nextState;
  logic [CWIDTH-1:0]   w_nextCnt;
  logic [CWIDTH-1:0]   w_nextPre;
  logic [CWIDTH-1:0]   w_nextHits;
  logic                w_nextOvr;
  logic                w_match;
  logic [CWIDTH-1:0]   w_hitsInc;

  // A stb=0 sample forces no match even if eq_ is unknown.
  assign w_match   = i_stb & ~i_eq_;
  assign w_hitsInc = (r_hits == {CWIDTH{1'b1}}) ? r_hits : r_hits + CWIDTH'(1);

  always_comb begin
    w_nextState = r_state;
    w_nextCnt   = r_cnt;
    w_nextPre   = r_pre;
    w_nextHits  = r_hits;
    w_nextOvr   = r_ovr;

    if (i_disarm) begin
      w_nextState = S_IDLE;
    end else if (i_arm) begin
      w_nextState = S_ARMED;
      w_nextHits  = '0;
      w_nextOvr   = 1'b0;
      w_nextCnt   = r_pre;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_nextState = S_IDLE;
        end
        S_ARMED: begin
          if (w_match) begin
            w_nextHits = w_hitsInc;
            if (r_cnt == '0) begin
              w_nextState = S_FIRE;
              w_nextCnt   = r_pre;
            end else begin
              w_nextCnt = r_cnt - CWIDTH'(1);
            end
          end
        end
        S_FIRE: begin
          // The reload already happened on entry, so ack just re-arms.
          if (i_ack) begin
            w_nextState = S_ARMED;
            if (w_match) begin
              w_nextHits = w_hitsInc;
            end
          end else if (w_match) begin
            w_nextHits = w_hitsInc;
            w_nextOvr  = 1'b1;
          end
        end
        default: begin
          w_nextState = S_IDLE;
        end
      endcase
    end

    if (i_ld) begin
      w_nextPre = i_cnt_in;
      w_nextCnt = i_cnt_in;
    end
  end

  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state <= S_IDLE;
      r_trig  <= 1'b0;
      r_armed <= 1'b0;
      r_cnt   <= '0;
      r_pre   <= '0;
      r_hits  <= '0;
      r_ovr   <= 1'b0;
    end else begin
      r_state <= w_nextState;
      r_trig  <= (w_nextState == S_FIRE);
      r_armed <= (w_nextState != S_IDLE);
      r_cnt   <= w_nextCnt;
      r_pre   <= w_nextPre;
      r_hits  <= w_nextHits;
      r_ovr   <= w_nextOvr;
    end
  end

  assign o_trig  = r_trig;
  assign o_armed = r_armed;
  assign o_cnt   = r_cnt;
  assign o_hits  = r_hits;
  assign o_ovr   = r_ovr;

endmodule

// File: tb/tb_addr_match_seq.sv
// Directed bench for addr_match_seq (CWIDTH=4): a vector table for the main
// flow plus hand-written sequences for gating, priority, saturation and reset.
module tb_addr_match_seq;

  localparam int CW = 4;

  logic          clk;
  logic          rst;
  logic          eq_;
  logic          stb;
  logic          ld;
  logic [CW-1:0] cntIn;
  logic          arm;
  logic          disarm;
  logic          ack;
  logic          trig;
  logic          armed;
  logic [CW-1:0] cnt;
  logic [CW-1:0] hits;
  logic          ovr;

  int compareCount = 0;
  int failCount    = 0;

  typedef struct {
    logic          stb;
    logic          eq;
    logic          ld;
    logic [CW-1:0] cntIn;
    logic          arm;
    logic          disarm;
    logic          ack;
    logic          trig;
    logic          armed;
    logic [CW-1:0] cnt;
    logic [CW-1:0] hits;
    logic          ovr;
  } vec_t;

  vec_t vecs[$];

  addr_match_seq #(.CWIDTH(CW)) dut (
    .i_clk    (clk),
    .i_rst    (rst),
    .i_eq_    (eq_),
    .i_stb    (stb),
    .i_ld     (ld),
    .i_cnt_in (cntIn),
    .i_arm    (arm),
    .i_disarm (disarm),
    .i_ack    (ack),
    .o_trig   (trig),
    .o_armed  (armed),
    .o_cnt    (cnt),
    .o_hits   (hits),
    .o_ovr    (ovr)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic addVec(input logic s, input logic e, input logic l, input logic [CW-1:0] ci,
                        input logic a, input logic d, input logic k,
                        input logic eT, input logic eA, input logic [CW-1:0] eC,
                        input logic [CW-1:0] eH, input logic eO);
    vec_t v;
    v.stb = s; v.eq = e; v.ld = l; v.cntIn = ci; v.arm = a; v.disarm = d; v.ack = k;
    v.trig = eT; v.armed = eA; v.cnt = eC; v.hits = eH; v.ovr = eO;
    vecs.push_back(v);
  endtask

  // Drive one edge's worth of inputs, then sample 1 time unit after the edge.
  task automatic applyStimulus(input logic s, input logic e, input logic l, input logic [CW-1:0] ci,
                               input logic a, input logic d, input logic k);
    stb = s; eq_ = e; ld = l; cntIn = ci; arm = a; disarm = d; ack = k;
    @(posedge clk);
    #1;
  endtask

  task automatic checkOutput(input string name, input logic eT, input logic eA,
                             input logic [CW-1:0] eC, input logic [CW-1:0] eH, input logic eO);
    compareCount++;
    if (trig !== eT || armed !== eA || cnt !== eC || hits !== eH || ovr !== eO) begin
      failCount++;
      $display("[TB] FAIL %s: got trig=%0b armed=%0b cnt=%0d hits=%0d ovr=%0b, expected trig=%0b armed=%0b cnt=%0d hits=%0d ovr=%0b",
               name, trig, armed, cnt, hits, ovr, eT, eA, eC, eH, eO);
    end
  endtask

  initial begin
    rst = 1'b1; stb = 1'b0; eq_ = 1'b1; ld = 1'b0; cntIn = '0;
    arm = 1'b0; disarm = 1'b0; ack = 1'b0;

    //      stb eq ld cin arm dis ack | trig armed cnt hits ovr
    addVec(0, 1, 1, 4'd2, 0, 0, 0,   0, 0, 4'd2, 4'd0, 0);
    addVec(0, 1, 0, 4'd0, 1, 0, 0,   0, 1, 4'd2, 4'd0, 0);
    addVec(1, 0, 0, 4'd0, 0, 0, 0,   0, 1, 4'd1, 4'd1, 0);
    addVec(1, 0, 0, 4'd0, 0, 0, 0,   0, 1, 4'd0, 4'd2, 0);
    addVec(1, 0, 0, 4'd0, 0, 0, 0,   1, 1, 4'd2, 4'd3, 0);
    addVec(1, 0, 0, 4'd0, 0, 0, 0,   1, 1, 4'd2, 4'd4, 1);
    addVec(1, 0, 0, 4'd0, 0, 0, 0,   1, 1, 4'd2, 4'd5, 1);
    addVec(0, 1, 0, 4'd0, 0, 0, 1,   0, 1, 4'd2, 4'd5, 1);
    addVec(0, 0, 0, 4'd0, 0, 0, 1,   0, 1, 4'd2, 4'd5, 1);
    addVec(1, 1, 0, 4'd0, 0, 0, 0,   0, 1, 4'd2, 4'd5, 1);
    addVec(0, 1, 0, 4'd0, 1, 0, 0,   0, 1, 4'd2, 4'd0, 0);
    addVec(1, 0, 0, 4'd0, 0, 0, 0,   0, 1, 4'd1, 4'd1, 0);
    addVec(1, 0, 0, 4'd0, 0, 1, 0,   0, 0, 4'd1, 4'd1, 0);
    addVec(1, 0, 0, 4'd0, 0, 0, 0,   0, 0, 4'd1, 4'd1, 0);
    addVec(0, 1, 1, 4'd0, 0, 0, 0,   0, 0, 4'd0, 4'd1, 0);
    addVec(0, 1, 0, 4'd0, 1, 0, 0,   0, 1, 4'd0, 4'd0, 0);
    addVec(1, 0, 0, 4'd0, 0, 0, 0,   1, 1, 4'd0, 4'd1, 0);
    addVec(1, 0, 0, 4'd0, 0, 0, 1,   0, 1, 4'd0, 4'd2, 0);
    addVec(1, 0, 1, 4'd5, 0, 0, 0,   1, 1, 4'd5, 4'd3, 0);
    addVec(1, 0, 0, 4'd0, 1, 0, 1,   0, 1, 4'd5, 4'd0, 0);
    addVec(0, 1, 1, 4'd3, 1, 0, 0,   0, 1, 4'd3, 4'd0, 0);

    #2;
    checkOutput("reset_state", 0, 0, 4'd0, 4'd0, 0);
    #10;
    rst = 1'b0;

    foreach (vecs[i]) begin
      applyStimulus(vecs[i].stb, vecs[i].eq, vecs[i].ld, vecs[i].cntIn,
                    vecs[i].arm, vecs[i].disarm, vecs[i].ack);
      checkOutput($sformatf("vec%0d", i), vecs[i].trig, vecs[i].armed,
                  vecs[i].cnt, vecs[i].hits, vecs[i].ovr);
    end

    // Non-matching strobes while ARMED (cnt=3, hits=0) must change nothing.
    for (int i = 0; i < 10; i++) begin
      if (i % 2 == 0) applyStimulus(0, 0, 0, 4'd0, 0, 0, 0);
      else            applyStimulus(1, 1, 0, 4'd0, 0, 0, 0);
      checkOutput($sformatf("gate%0d", i), 0, 1, 4'd3, 4'd0, 0);
    end
    applyStimulus(0, 1'bx, 0, 4'd0, 0, 0, 0);
    checkOutput("gate_eq_x", 0, 1, 4'd3, 4'd0, 0);

    // All four requests in one edge during FIRE: disarm wins.
    applyStimulus(0, 1, 1, 4'd0, 0, 0, 0);
    checkOutput("prio_ld0", 0, 1, 4'd0, 4'd0, 0);
    applyStimulus(1, 0, 0, 4'd0, 0, 0, 0);
    checkOutput("prio_fire", 1, 1, 4'd0, 4'd1, 0);
    applyStimulus(1, 0, 0, 4'd0, 1, 1, 1);
    checkOutput("prio_all", 0, 0, 4'd0, 4'd1, 0);

    // pre=0 with match+ack every cycle: trig alternates, hits saturates at 15.
    applyStimulus(0, 1, 0, 4'd0, 1, 0, 0);
    checkOutput("sat_arm", 0, 1, 4'd0, 4'd0, 0);
    for (int i = 0; i < 20; i++) begin
      applyStimulus(1, 0, 0, 4'd0, 0, 0, 1);
      checkOutput($sformatf("sat%0d", i), (i % 2 == 0), 1, 4'd0,
                  (i + 1 > 15) ? 4'd15 : 4'(i + 1), 0);
    end

    // Reach FIRE with hits=5 and ovr set, then reset asynchronously mid-cycle.
    applyStimulus(0, 1, 0, 4'd0, 1, 0, 0);
    checkOutput("rst_arm", 0, 1, 4'd0, 4'd0, 0);
    applyStimulus(1, 0, 0, 4'd0, 0, 0, 0);
    checkOutput("rst_fire", 1, 1, 4'd0, 4'd1, 0);
    for (int i = 0; i < 4; i++) applyStimulus(1, 0, 0, 4'd0, 0, 0, 0);
    checkOutput("rst_pre", 1, 1, 4'd0, 4'd5, 1);
    #2;
    rst = 1'b1;
    #1;
    checkOutput("rst_async", 0, 0, 4'd0, 4'd0, 0);
    #1;
    rst = 1'b0;
    applyStimulus(1, 0, 0, 4'd0, 1, 0, 0);
    checkOutput("rst_recover", 0, 1, 4'd0, 4'd0, 0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compareCount, failCount);
    $finish;
  end

endmodule
